// File: rtl/seg_scan_sched_pkg.sv
// rtl/seg_scan_sched_pkg.sv - shared display constants and scan state type
package seg_scan_sched_pkg;

  localparam int N_DIG = 8;
  localparam int IDX_W = 3;
  localparam int NIB_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/seg_next_sel.sv
// rtl/seg_next_sel.sv - finds the next enabled digit after ptr, flagging a wrap to the lowest
module seg_next_sel
  import seg_scan_sched_pkg::*;
(
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_DIG-1:0] digit_en,
  output logic [IDX_W-1:0] nxt,
  output logic             wrap,
  output logic             any_en
);

  logic [IDX_W-1:0] w_lo;
  logic [IDX_W-1:0] w_hi;
  logic             w_found;

  // Scanning downward leaves the lowest matching index in each candidate.
  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_found = 1'b0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      if (digit_en[i]) begin
        w_lo = IDX_W'(i);
        if (IDX_W'(i) > ptr) begin
          w_hi    = IDX_W'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  assign any_en = |digit_en;
  assign wrap   = !w_found;
  assign nxt    = w_found ? w_hi : w_lo;

endmodule

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - blanked, double-buffered seven-segment scan scheduler
module seg_scan_sched
  import seg_scan_sched_pkg::*;
#(
  parameter int DWELL = 10000,
  parameter int BLANK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [NIB_W-1:0] wr_data,
  input  logic             commit,
  output logic             commit_pend,
  input  logic [N_DIG-1:0] digit_en,
  output logic [NIB_W-1:0] out,
  output logic [IDX_W-1:0] an,
  output logic             blank,
  output logic             frame_done
);

  localparam int T_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic             r_fresh;
  logic [NIB_W-1:0] r_active [N_DIG];
  logic [NIB_W-1:0] r_shadow [N_DIG];
  logic [NIB_W-1:0] r_out;
  logic [IDX_W-1:0] r_an;
  logic             r_blank;
  logic             r_commit_pend;
  logic             r_frame_done;

  logic [IDX_W-1:0] w_sel_ptr;
  logic [IDX_W-1:0] w_nxt;
  logic             w_wrap;
  logic             w_any_en;
  logic             w_pick;
  logic             w_boundary;
  logic             w_apply;

  // Until the first selection after reset, pretend ptr sits at the top so the
  // scan starts at the lowest enabled digit and counts as a frame boundary.
  assign w_sel_ptr = r_fresh ? IDX_W'(N_DIG - 1) : r_ptr;

  seg_next_sel u_next_sel (
    .ptr      (w_sel_ptr),
    .digit_en (digit_en),
    .nxt      (w_nxt),
    .wrap     (w_wrap),
    .any_en   (w_any_en)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_pick      = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_timer == TW'(BLANK - 1)) begin
          w_timer_nxt = '0;
          if (w_any_en) begin
            w_pick      = 1'b1;
            w_state_nxt = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (r_timer == TW'(DWELL - 1) || !digit_en[r_ptr]) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_BLANK;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = ST_BLANK;
      end
    endcase
  end

  assign w_boundary = w_pick && w_wrap;
  assign w_apply    = w_boundary && r_commit_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BLANK;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_DIG; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_ptr         <= '0;
      r_fresh       <= 1'b1;
      r_out         <= '0;
      r_an          <= '0;
      r_blank       <= 1'b1;
      r_commit_pend <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      if (wr_en) begin
        r_shadow[wr_addr] <= wr_data;
      end
      // The copy reads the pre-edge shadow, so a same-cycle write waits for the next commit.
      if (w_apply) begin
        for (int i = 0; i < N_DIG; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_commit_pend <= commit;
      end else if (commit) begin
        r_commit_pend <= 1'b1;
      end
      if (w_pick) begin
        r_ptr   <= w_nxt;
        r_fresh <= 1'b0;
        r_an    <= w_nxt;
        r_out   <= w_apply ? r_shadow[w_nxt] : r_active[w_nxt];
      end
      r_blank      <= (w_state_nxt == ST_BLANK);
      r_frame_done <= w_boundary;
    end
  end

  assign out         = r_out;
  assign an          = r_an;
  assign blank       = r_blank;
  assign commit_pend = r_commit_pend;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb/tb_seg_scan_sched.sv - self-checking bench for seg_scan_sched
module tb_seg_scan_sched;

  localparam int DWELL_C = 4;
  localparam int BLANK_C = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [7:0] digit_en = 8'hFF;
  logic       commit_pend;
  logic [3:0] out;
  logic [2:0] an;
  logic       blank;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_sched #(.DWELL(DWELL_C), .BLANK(BLANK_C)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_pend (commit_pend),
    .digit_en    (digit_en),
    .out         (out),
    .an          (an),
    .blank       (blank),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: countdown of cycles left in the current phase, modular search for the next digit.
  bit         m_show;
  int         m_left;
  int         m_ptr;
  bit         m_fresh;
  bit         m_pend;
  bit         m_fd;
  int         m_an;
  logic [3:0] m_out;
  logic [3:0] m_act [8];
  logic [3:0] m_sh [8];
  logic [3:0] sh_old [8];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_show = 0; m_left = BLANK_C; m_ptr = 0; m_fresh = 1; m_pend = 0; m_fd = 0;
      m_an = 0; m_out = '0;
      for (int i = 0; i < 8; i++) begin m_act[i] = '0; m_sh[i] = '0; end
    end else begin
      int base, idx;
      bit found;
      m_fd = 0;
      sh_old = m_sh;
      if (wr_en) m_sh[wr_addr] = wr_data;
      m_left = m_left - 1;
      if (m_show) begin
        if (m_left == 0 || !digit_en[m_ptr]) begin m_show = 0; m_left = BLANK_C; end
      end else if (m_left == 0) begin
        m_left = BLANK_C;
        if (digit_en != 8'h00) begin
          base = m_fresh ? 7 : m_ptr;
          found = 0; idx = 0;
          for (int k = 1; k <= 8; k++) begin
            if (!found && digit_en[(base + k) % 8]) begin idx = (base + k) % 8; found = 1; end
          end
          if (idx <= base) begin
            m_fd = 1;
            if (m_pend) begin m_act = sh_old; m_pend = 0; end
          end
          m_ptr = idx; m_an = idx; m_out = m_act[idx];
          m_show = 1; m_left = DWELL_C; m_fresh = 0;
        end
      end
      if (commit) m_pend = 1;
    end
  end

  int q_an [$];
  int q_out [$];
  int fd_cnt = 0;
  bit saw_show = 0;
  bit prev_blank = 1;

  always @(negedge clk) begin
    chk("out", out, m_out);
    chk("an", an, m_an);
    chk("blank", blank, !m_show);
    chk("commit_pend", commit_pend, m_pend);
    chk("frame_done", frame_done, m_fd);
    if (prev_blank && !blank) begin q_an.push_back(an); q_out.push_back(out); end
    prev_blank = blank;
    if (frame_done) fd_cnt++;
    if (!blank) saw_show = 1;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_logs();
    q_an.delete(); q_out.delete(); fd_cnt = 0; saw_show = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int got, cnt;
    int exp_sp [4];
    exp_sp = '{2, 5, 7, 2};

    tick(3);
    chk("rst_out", out, 0); chk("rst_an", an, 0); chk("rst_blank", blank, 1);
    chk("rst_pend", commit_pend, 0); chk("rst_fd", frame_done, 0);
    rst = 1'b1;
    clear_logs();
    tick(50);
    chk("scan_len", q_an.size(), 9);
    for (int i = 0; i < 8; i++) chk("scan_an", q_an[i], i);
    chk("scan_an_wrap", q_an[8], 0);
    chk("scan_fd", fd_cnt, 2);

    digit_en = 8'b1010_0100;
    clear_logs();
    tick(40);
    chk("sparse_len", q_an.size(), 7);
    for (int i = 0; i < 4; i++) chk("sparse_an", q_an[i], exp_sp[i]);
    foreach (q_an[i]) chk("sparse_enabled", digit_en[q_an[i]], 1);
    chk("sparse_fd", fd_cnt, 2);

    digit_en = 8'hFF;
    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 4'(a + 1);
      tick(1);
    end
    wr_en = 1'b0; commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("commit_pend_set", commit_pend, 1);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin tick(1); if (frame_done) got = 1; end
    chk("commit_wrap_seen", got, 1);
    chk("commit_cleared", commit_pend, 0);
    chk("commit_an0", an, 0);
    chk("commit_out0", out, 1);
    clear_logs();

    tick(46);
    commit = 1'b1;
    tick(1);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF; commit = 1'b1;
    tick(1);
    wr_en = 1'b0; commit = 1'b0;
    chk("coll_fd", frame_done, 1);
    chk("coll_pend_kept", commit_pend, 1);
    chk("coll_out0", out, 1);
    chk("frame1_len", q_out.size(), 8);
    for (int i = 0; i < 7; i++) chk("frame1_out", q_out[i], i + 2);
    chk("frame1_out_wrap", q_out[7], 1);
    clear_logs();
    tick(48);
    chk("coll_an3", q_an[2], 3);
    chk("coll_old_val", q_out[2], 4);
    chk("coll_fd2", frame_done, 1);
    chk("coll_pend_clr", commit_pend, 0);
    clear_logs();
    tick(48);
    chk("coll_new_val", q_out[2], 15);

    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    chk("pre_rst_pend", commit_pend, 1);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin tick(1); if (!blank && an == 3'd5) got = 1; end
    chk("reach_digit5", got, 1);
    rst = 1'b0; digit_en = 8'h00;
    #1;
    chk("mid_rst_out", out, 0); chk("mid_rst_an", an, 0); chk("mid_rst_blank", blank, 1);
    chk("mid_rst_pend", commit_pend, 0); chk("mid_rst_fd", frame_done, 0);
    clear_logs();
    tick(2);
    rst = 1'b1;
    tick(20);
    chk("empty_fd", fd_cnt, 0);
    chk("empty_dark", saw_show, 0);

    digit_en = 8'h10;
    got = 0; cnt = 0;
    for (int i = 0; i < 4 && !got; i++) begin tick(1); cnt++; if (!blank) got = 1; end
    chk("single_seen", got, 1);
    chk("single_lat", cnt <= 2, 1);
    chk("single_an", an, 4);
    chk("single_out", out, 0);
    chk("single_fd", frame_done, 1);
    fd_cnt = 0;
    tick(24);
    chk("single_fd_rate", fd_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
